mac_exec_unit: RTL and testbench
================================

MAC_EXEC_UNIT -- requirements
Module: mac_exec_unit

Interface
REQ-001 The block SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have ports: mac_op_e  in  mac_op_t  MAC operation from the decode/execute control register.
REQ-003 The block SHALL have ports: mac_write_e  in  1  qualifies mac_op_e as a live MAC instruction in execute.
REQ-004 The block SHALL have ports: src_a_e, src_b_e  in  32 each  forwarded unsigned operands.
REQ-005 The block SHALL have ports: kill_e  in  1  abort in-flight operation (exception/flush).
REQ-006 The block SHALL have ports: mac_stall  out  1  stall request to the hazard unit.
REQ-007 The block SHALL have ports: mac_lo, mac_hi  out  32 each  accumulator low/high words.
REQ-008 The block SHALL have ports: mac_done  out  1  one-cycle pulse when the accumulator updates.

Function
REQ-009 The accumulator SHALL be 64 bits; mac_lo = acc[31:0], mac_hi = acc[63:32], driven directly from the register.
REQ-010 mac_op_t encodings SHALL be MAC_NOP=0, MAC_MUL=1 (acc = a*b), MAC_MAC=2 (acc = acc + a*b), MAC_CLR=3 (acc = 0).
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 start SHALL equal state==IDLE && mac_write_e && mac_op_e in {MUL, MAC} && !kill_e.
REQ-013 IDLE on start: latch a, b and the op; clear the 64-bit partial product; set chunk counter = 0; go to CALC.
REQ-014 IDLE with mac_write_e && MAC_CLR && !kill_e: acc <= 0 in the same edge, no stall, mac_done = 0, stay in IDLE.
REQ-015 CALC: each cycle, product += (a * b[8k+7:8k]) << 8k, where k = counter, then increment counter.
REQ-016 CALC with k==3: after the chunk is added, write acc <= product (MUL) or acc + product (MAC) mod 2^64, then go to DONE.
REQ-017 DONE: mac_done = 1 and mac_stall = 0 for exactly one cycle, then go to IDLE.
REQ-018 DONE: start SHALL be ignored, because the same instruction still occupies execute during that cycle.
REQ-019 mac_stall SHALL be combinational, = start || state==CALC; occupancy is 6 cycles, of which 5 are stalled.
REQ-020 The updated acc SHALL be visible on mac_lo/mac_hi from the DONE cycle onward.
REQ-021 kill_e in CALC or DONE: go to IDLE next edge, acc unchanged, mac_done = 0, mac_stall = 0 in that cycle.
REQ-022 MAC_NOP, or mac_write_e = 0, SHALL have no effect.
REQ-023 The multiply SHALL be unsigned; no overflow flag; MAC accumulation wraps modulo 2^64.
REQ-024 Operands SHALL be sampled only at start; later changes to src_a_e/src_b_e during CALC SHALL be ignored.

Reset
REQ-025 rst SHALL be synchronous, active-high and dominate all other inputs.
REQ-026 On rst: state = IDLE, acc = 0, product = 0, counter = 0, latched a/b/op = 0, mac_done = 0, mac_stall = 0.
REQ-027 rst asserted mid-CALC SHALL abort the operation, with acc = 0 after the reset edge.

Structure
REQ-028 mac_op_t with its encodings, the FSM state enum mac_state_t, and the constant MAC_CHUNKS = 4 SHALL live in the shared types package.
REQ-029 The 32x8 partial-product multiplier SHALL be a combinational sub-module named mac_partial_mult (a[31:0], b_byte[7:0] -> pp[39:0]).
REQ-030 The block SHALL contain no other sub-modules; all registers SHALL use one clk domain.

Verification
REQ-031 The bench SHALL cover: MUL 0xFFFFFFFF * 0xFFFFFFFF -> mac_stall high for 5 cycles, mac_done on the 6th, mac_hi = 0xFFFFFFFE, mac_lo = 0x00000001.
REQ-032 The bench SHALL cover: MUL 3*4 then MAC 5*6 back-to-back -> acc = 12 then 42; two mac_done pulses 6 cycles apart.
REQ-033 The bench SHALL cover: acc = 0xFFFFFFFF_FFFFFFFF, MAC 1*1 -> acc = 0 (wrap), no other flag.
REQ-034 The bench SHALL cover: MUL 7*9 with kill_e in the 2nd CALC cycle -> IDLE next cycle, acc keeps its prior value 42, no mac_done.
REQ-035 The bench SHALL cover: MAC_CLR with acc = 42 -> acc = 0 next cycle, mac_stall never high; rst mid-CALC -> all outputs 0.
REQ-036 The bench SHALL cover: mac_op_e held at MAC_MUL with mac_write_e high through DONE -> exactly one operation and one mac_done.

Source files
------------

// File: rtl/mac_exec_unit_pkg.sv
// Shared types for the multiply-accumulate execute unit.
package mac_exec_unit_pkg;

  typedef enum logic [1:0] {
    MAC_NOP = 2'd0,
    MAC_MUL = 2'd1,
    MAC_MAC = 2'd2,
    MAC_CLR = 2'd3
  } mac_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mac_state_t;

  // The 32-bit b operand is consumed one byte per CALC cycle.
  localparam int MAC_CHUNKS = 4;
  localparam int MAC_CNT_W  = $clog2(MAC_CHUNKS);

endpackage

// File: rtl/mac_partial_mult.sv
// Combinational 32x8 unsigned partial-product multiplier.
module mac_partial_mult (
  input  logic [31:0] a,
  input  logic [7:0]  b_byte,
  output logic [39:0] pp
);

  assign pp = {8'b0, a} * {32'b0, b_byte};

endmodule

// File: rtl/mac_exec_unit.sv
// Multi-cycle MAC execute unit: byte-serial unsigned multiply into a 64-bit
// accumulator, stalling the pipeline while the product is built.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a live MUL/MAC; MAC_CLR handled here in one edge
// ST_CALC | adding one shifted 32x8 partial product per cycle
// ST_DONE | accumulator updated; instruction leaves execute this cycle
module mac_exec_unit
  import mac_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mac_op_t     mac_op_e,
  input  logic        mac_write_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        kill_e,
  output logic        mac_stall,
  output logic [31:0] mac_lo,
  output logic [31:0] mac_hi,
  output logic        mac_done
);

  mac_state_t           state;
  mac_op_t              op_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic [63:0]          acc;
  logic [63:0]          product;
  logic [MAC_CNT_W-1:0] cnt;

  logic        start;
  logic        clr;
  logic        last_chunk;
  logic [7:0]  b_byte;
  logic [39:0] pp;
  logic [63:0] pp_shift;
  logic [63:0] product_next;

  // Reset and kill both suppress a new operation in the same cycle.
  assign start = !rst && (state == ST_IDLE) && mac_write_e && !kill_e &&
                 ((mac_op_e == MAC_MUL) || (mac_op_e == MAC_MAC));
  assign clr   = !rst && (state == ST_IDLE) && mac_write_e && !kill_e &&
                 (mac_op_e == MAC_CLR);

  assign last_chunk   = (cnt == MAC_CNT_W'(MAC_CHUNKS - 1));
  assign b_byte       = b_q[{cnt, 3'b000} +: 8];
  assign pp_shift     = {24'b0, pp} << {cnt, 3'b000};
  assign product_next = product + pp_shift;

  mac_partial_mult u_pmult (
    .a      (a_q),
    .b_byte (b_byte),
    .pp     (pp)
  );

  assign mac_stall = start || (!rst && !kill_e && (state == ST_CALC));
  assign mac_done  = !rst && !kill_e && (state == ST_DONE);
  assign mac_lo    = acc[31:0];
  assign mac_hi    = acc[63:32];

  // Control FSM plus operand latch, partial-product sum and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= MAC_NOP;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      product <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q     <= src_a_e;
            b_q     <= src_b_e;
            op_q    <= mac_op_e;
            product <= '0;
            cnt     <= '0;
            state   <= ST_CALC;
          end else if (clr) begin
            acc <= '0;
          end
        end
        ST_CALC: begin
          if (kill_e) begin
            state <= ST_IDLE;
          end else begin
            product <= product_next;
            cnt     <= cnt + MAC_CNT_W'(1);
            if (last_chunk) begin
              acc   <= (op_q == MAC_MUL) ? product_next : (acc + product_next);
              state <= ST_DONE;
            end
          end
        end
        // The issuing instruction is still in execute here, so no restart.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_exec_unit.sv
// Self-checking bench for mac_exec_unit: directed corner cases followed by
// randomized instruction streams checked against a transaction-level model.
module tb_mac_exec_unit;
  import mac_exec_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  mac_op_t     mac_op_e;
  logic        mac_write_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        kill_e;
  logic        mac_stall;
  logic [31:0] mac_lo;
  logic [31:0] mac_hi;
  logic        mac_done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_done_cyc = -1;
  logic [63:0] acc_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mac_op_e    (mac_op_e),
    .mac_write_e (mac_write_e),
    .src_a_e     (src_a_e),
    .src_b_e     (src_b_e),
    .kill_e      (kill_e),
    .mac_stall   (mac_stall),
    .mac_lo      (mac_lo),
    .mac_hi      (mac_hi),
    .mac_done    (mac_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] acc_dut();
    return {mac_hi, mac_lo};
  endfunction

  // One quiet cycle with no live instruction; nothing may change.
  task automatic idle_cycle(input string tag);
    mac_write_e = 1'b0;
    kill_e      = 1'b0;
    mac_op_e    = mac_op_t'($urandom_range(0, 3));
    @(negedge clk);
    chk({tag, "_stall"}, 64'(mac_stall), 64'd0);
    chk({tag, "_done"},  64'(mac_done),  64'd0);
    chk({tag, "_acc"},   acc_dut(),      acc_m);
    @(posedge clk); #1;
  endtask

  // Issue a MUL/MAC and hold it in execute through DONE, as the pipeline does.
  // kill_at: cycle index (0 = issue cycle, 1..4 = CALC) to raise kill_e, or -1.
  task automatic run_op(input string tag, input mac_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int kill_at);
    logic [63:0] acc_old;
    logic [63:0] acc_new;
    logic [63:0] prod;
    bit killed;
    acc_old = acc_m;
    prod    = 64'(a) * 64'(b);
    acc_new = (op == MAC_MUL) ? prod : acc_m + prod;
    killed  = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        mac_write_e = 1'b1;
        mac_op_e    = op;
        src_a_e     = a;
        src_b_e     = b;
      end else begin
        src_a_e = $urandom;
        src_b_e = $urandom;
      end
      kill_e = (i == kill_at);
      if (i == kill_at && i != 0) mac_write_e = 1'b0;
      @(negedge clk);
      if (i == kill_at) begin
        chk({tag, "_kill_stall"}, 64'(mac_stall), 64'd0);
        chk({tag, "_kill_done"},  64'(mac_done),  64'd0);
        killed = 1;
      end else begin
        chk({tag, "_stall"}, 64'(mac_stall), 64'(i < 5));
        chk({tag, "_done"},  64'(mac_done),  64'(i == 5));
        chk({tag, "_acc"},   acc_dut(),      (i == 5) ? acc_new : acc_old);
        if (i == 5) last_done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (killed) begin
        kill_e      = 1'b0;
        mac_write_e = 1'b0;
        break;
      end
    end
    if (killed) idle_cycle({tag, "_postkill"});
    else acc_m = acc_new;
  endtask

  task automatic run_clr(input string tag);
    mac_write_e = 1'b1;
    mac_op_e    = MAC_CLR;
    kill_e      = 1'b0;
    src_a_e     = $urandom;
    src_b_e     = $urandom;
    @(negedge clk);
    chk({tag, "_stall"}, 64'(mac_stall), 64'd0);
    chk({tag, "_done"},  64'(mac_done),  64'd0);
    @(posedge clk); #1;
    acc_m = 64'd0;
    idle_cycle({tag, "_after"});
  endtask

  // A NOP or an unqualified op: no stall, no done, accumulator untouched.
  task automatic run_noeffect(input string tag, input bit use_nop);
    mac_write_e = use_nop;
    mac_op_e    = use_nop ? MAC_NOP : mac_op_t'($urandom_range(1, 3));
    kill_e      = 1'b0;
    src_a_e     = $urandom;
    src_b_e     = $urandom;
    @(negedge clk);
    chk({tag, "_stall"}, 64'(mac_stall), 64'd0);
    chk({tag, "_done"},  64'(mac_done),  64'd0);
    @(posedge clk); #1;
    idle_cycle({tag, "_after"});
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'd0;
      2:       return 32'(1 << $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  int d1;

  initial begin
    rst = 1'b1; mac_write_e = 1'b0; mac_op_e = MAC_NOP;
    src_a_e = '0; src_b_e = '0; kill_e = 1'b0;
    acc_m = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_acc",   acc_dut(),       64'd0);
    chk("rst_stall", 64'(mac_stall),  64'd0);
    chk("rst_done",  64'(mac_done),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Largest product; stall for 5 cycles, done on the 6th.
    run_op("mul_max", MAC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    idle_cycle("mul_max_idle");
    chk("mul_max_val", acc_dut(), 64'hFFFF_FFFE_0000_0001);

    // Bring acc to all ones, then wrap it with MAC 1*1.
    run_op("mac_fill", MAC_MAC, 32'd2, 32'hFFFF_FFFF, -1);
    idle_cycle("mac_fill_idle");
    chk("mac_fill_val", acc_dut(), 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mac_wrap", MAC_MAC, 32'd1, 32'd1, -1);
    idle_cycle("mac_wrap_idle");
    chk("mac_wrap_val", acc_dut(), 64'd0);

    // Back-to-back MUL then MAC.
    run_op("mul_3x4", MAC_MUL, 32'd3, 32'd4, -1);
    chk("mul_3x4_val", acc_dut(), 64'd12);
    d1 = last_done_cyc;
    run_op("mac_5x6", MAC_MAC, 32'd5, 32'd6, -1);
    chk("mac_5x6_val", acc_dut(), 64'd42);
    chk("b2b_done_gap", 64'(last_done_cyc - d1), 64'd6);
    idle_cycle("b2b_idle");

    // Kill in the 2nd CALC cycle.
    run_op("kill_7x9", MAC_MUL, 32'd7, 32'd9, 2);
    chk("kill_keep42", acc_dut(), 64'd42);

    run_clr("clr42");
    chk("clr42_val", acc_dut(), 64'd0);

    // Instruction held through DONE must run only once (idle checks stall=0).
    run_op("hold_mul", MAC_MUL, 32'h1234_5678, 32'h9ABC_DEF0, -1);
    idle_cycle("hold_mul_idle");

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: run_op("r_mul", MAC_MUL, rand_operand(), rand_operand(), -1);
        3, 4, 5: run_op("r_mac", MAC_MAC, rand_operand(), rand_operand(), -1);
        6:       run_op("r_kill", ($urandom_range(0, 1) != 0) ? MAC_MUL : MAC_MAC,
                        rand_operand(), rand_operand(), int'($urandom_range(0, 4)));
        7:       run_clr("r_clr");
        8:       run_noeffect("r_nop", 1'b1);
        default: run_noeffect("r_nowr", 1'b0);
      endcase
      if ($urandom_range(0, 1) != 0) idle_cycle("r_gap");
    end

    // Reset mid-CALC clears everything.
    run_op("pre_rst", MAC_MUL, 32'd100, 32'd200, -1);
    idle_cycle("pre_rst_idle");
    mac_write_e = 1'b1; mac_op_e = MAC_MAC; src_a_e = 32'd11; src_b_e = 32'd13;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", 64'(mac_stall), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; mac_write_e = 1'b0;
    acc_m = 64'd0;
    @(negedge clk);
    chk("rst_mid_acc",   acc_dut(),      64'd0);
    chk("rst_mid_stall2", 64'(mac_stall), 64'd0);
    chk("rst_mid_done",  64'(mac_done),  64'd0);
    @(posedge clk); #1;
    repeat (6) idle_cycle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
